// File: rtl/logistic_regression_hls_deadlock_reporter.sv
`default_nettype none
// logistic_regression_hls_deadlock_reporter: persistence-filters HLS monitor block flags,
// latches the first confirmed deadlock with irq. Optional counter: DEADLOCK_REPORTER_EVCNT_EN.
module logistic_regression_hls_deadlock_reporter #(
  parameter int NUM_MON        = 1,
  parameter int IDX_W          = 1,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_W           = 32,
  parameter int EVT_W          = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] block_sigs,
  input  logic               clear,
  output logic               deadlock,
  output logic [NUM_MON-1:0] deadlock_vec,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic [TS_W-1:0]    deadlock_ts,
  output logic               irq,
  output logic [1:0]         state,
  output logic [EVT_W-1:0]   event_count
);

  localparam int PC_W = (PERSIST_CYCLES > 1) ? $clog2(PERSIST_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PERSIST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MON     = 2'd1,
    ST_HIT     = 2'd2,
    ST_LATCHED = 2'd3
  } state_t;

  state_t             cur_state, next_state;
  logic [TS_W-1:0]    ts;
  logic [PC_W-1:0]    pc [NUM_MON];
  logic [NUM_MON-1:0] hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               confirm;
  logic               release_st;

  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int i = 0; i < NUM_MON; i++) begin
      hit[i] = (cur_state == ST_MON) && block_sigs[i] && (pc[i] == PC_LAST);
    end
    // Scan downward so the lowest set index is the last one written.
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  // Dropping enable out of MON wins over a simultaneous confirmation.
  assign confirm    = (cur_state == ST_MON) && enable && (|hit);
  assign release_st = (cur_state == ST_LATCHED) && clear;

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_IDLE:    if (enable) next_state = ST_MON;
      ST_MON: begin
        if (!enable)     next_state = ST_IDLE;
        else if (|hit)   next_state = ST_HIT;
      end
      ST_HIT:     next_state = ST_LATCHED;
      ST_LATCHED: if (clear) next_state = enable ? ST_MON : ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= ST_IDLE;
    else        cur_state <= next_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       ts <= '0;
    else if (enable && (ts != '1))    ts <= ts + TS_W'(1);
  end

  // Counts only while staying in MON; every other path returns it to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MON; i++) pc[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if ((cur_state == ST_MON) && enable && !clear && !(|hit) && block_sigs[i])
          pc[i] <= pc[i] + PC_W'(1);
        else
          pc[i] <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deadlock     <= 1'b0;
      deadlock_vec <= '0;
      deadlock_idx <= '0;
      deadlock_ts  <= '0;
    end else if (confirm) begin
      deadlock     <= 1'b1;
      deadlock_vec <= hit;
      deadlock_idx <= hit_idx;
      deadlock_ts  <= ts;
    end else if (release_st) begin
      deadlock     <= 1'b0;
      deadlock_vec <= '0;
      deadlock_idx <= '0;
      deadlock_ts  <= '0;
    end
  end

  assign irq   = (cur_state == ST_HIT);
  assign state = cur_state;

`ifdef DEADLOCK_REPORTER_EVCNT_EN
  logic [EVT_W-1:0] evt_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           evt_cnt <= '0;
    else if (confirm && (evt_cnt != '1))  evt_cnt <= evt_cnt + EVT_W'(1);
  end

  assign event_count = evt_cnt;
`else
  assign event_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logistic_regression_hls_deadlock_reporter.sv
`default_nettype none
// Bench for logistic_regression_hls_deadlock_reporter: cycle model plus directed literal pins.
module tb_logistic_regression_hls_deadlock_reporter;

  localparam int NUM_MON = 2;
  localparam int IDX_W   = 1;
  localparam int P       = 16;
  localparam int TS_W    = 8;
  localparam int EVT_W   = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic [NUM_MON-1:0] block_sigs;
  logic               clear;
  logic               deadlock;
  logic [NUM_MON-1:0] deadlock_vec;
  logic [IDX_W-1:0]   deadlock_idx;
  logic [TS_W-1:0]    deadlock_ts;
  logic               irq;
  logic [1:0]         state;
  logic [EVT_W-1:0]   event_count;

  int checks = 0;
  int errors = 0;

  logistic_regression_hls_deadlock_reporter #(
    .NUM_MON(NUM_MON), .IDX_W(IDX_W), .PERSIST_CYCLES(P), .TS_W(TS_W), .EVT_W(EVT_W)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .block_sigs(block_sigs), .clear(clear),
    .deadlock(deadlock), .deadlock_vec(deadlock_vec), .deadlock_idx(deadlock_idx),
    .deadlock_ts(deadlock_ts), .irq(irq), .state(state), .event_count(event_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 monitoring, 2 just confirmed, 3 holding.
  int               m_mode;
  int               m_run [NUM_MON];
  logic [TS_W-1:0]  m_ts;
  logic             m_dl;
  logic [NUM_MON-1:0] m_vec;
  logic [IDX_W-1:0] m_idx;
  logic [TS_W-1:0]  m_dts;
  int               m_ev;

  task automatic model_reset();
    m_mode = 0; m_ts = '0; m_dl = 1'b0; m_vec = '0; m_idx = '0; m_dts = '0; m_ev = 0;
    for (int i = 0; i < NUM_MON; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [NUM_MON-1:0] h;
    logic [TS_W-1:0]    old_ts;
    h = '0;
    if (m_mode == 1)
      for (int i = 0; i < NUM_MON; i++) h[i] = block_sigs[i] && (m_run[i] == P - 1);
    old_ts = m_ts;
    if (enable && m_ts != {TS_W{1'b1}}) m_ts = m_ts + 1'b1;
    case (m_mode)
      0: begin
        for (int i = 0; i < NUM_MON; i++) m_run[i] = 0;
        if (enable) m_mode = 1;
      end
      1: begin
        if (!enable) begin
          m_mode = 0;
          for (int i = 0; i < NUM_MON; i++) m_run[i] = 0;
        end else if (h != 0) begin
          m_dl = 1'b1; m_vec = h; m_dts = old_ts;
          for (int i = NUM_MON - 1; i >= 0; i--) if (h[i]) m_idx = IDX_W'(i);
          if (m_ev < (1 << EVT_W) - 1) m_ev++;
          m_mode = 2;
          for (int i = 0; i < NUM_MON; i++) m_run[i] = 0;
        end else begin
          for (int i = 0; i < NUM_MON; i++)
            m_run[i] = (clear || !block_sigs[i]) ? 0 : m_run[i] + 1;
        end
      end
      2: m_mode = 3;
      default: begin
        if (clear) begin
          m_dl = 1'b0; m_vec = '0; m_idx = '0; m_dts = '0;
          m_mode = enable ? 1 : 0;
        end
      end
    endcase
  endtask

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
    #1;
    check("deadlock", deadlock, m_dl);
    check("deadlock_vec", deadlock_vec, m_vec);
    check("deadlock_idx", deadlock_idx, m_idx);
    check("deadlock_ts", deadlock_ts, m_dts);
    check("irq", irq, m_mode == 2);
    check("state", state, m_mode);
`ifdef DEADLOCK_REPORTER_EVCNT_EN
    check("event_count", event_count, m_ev);
`else
    check("event_count", event_count, 0);
`endif
  end

  task automatic release_latch();
    block_sigs = '0; enable = 1'b1;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  initial begin
    int pulses;
    reset = 1'b0; enable = 1'b0; block_sigs = '0; clear = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", state, 0);
    check("rst_deadlock", deadlock, 0);
    check("rst_ts", deadlock_ts, 0);

    // Quiet monitoring for 100 cycles, then a 16-cycle block on monitor 1.
    reset = 1'b1; enable = 1'b1;
    repeat (100) @(negedge clock);
    check("quiet_state", state, 1);
    check("quiet_deadlock", deadlock, 0);
    block_sigs = 2'b10;
    repeat (16) @(negedge clock);
    check("t2_irq", irq, 1);
    check("t2_vec", deadlock_vec, 2'b10);
    check("t2_idx", deadlock_idx, 1);
    check("t2_ts", deadlock_ts, 115);

    // Holding: inputs ignored while latched.
    repeat (50) begin
      enable = 1'($urandom); block_sigs = 2'($urandom);
      @(negedge clock);
    end
    check("hold_state", state, 3);
    check("hold_vec", deadlock_vec, 2'b10);
    check("hold_ts", deadlock_ts, 115);
    enable = 1'b1; block_sigs = '0; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_state", state, 1);
    check("clr_deadlock", deadlock, 0);
    block_sigs = 2'b01;
    repeat (16) @(negedge clock);
    check("reconf_irq", irq, 1);
    check("reconf_vec", deadlock_vec, 2'b01);
    release_latch();

    // A one-cycle gap restarts the count: 15 high, 1 low, 16 high.
    block_sigs = 2'b01;
    repeat (15) @(negedge clock);
    block_sigs = 2'b00;
    @(negedge clock);
    block_sigs = 2'b01;
    repeat (15) @(negedge clock);
    check("gap_no_irq", irq, 0);
    @(negedge clock);
    check("gap_irq", irq, 1);
    release_latch();

    // Simultaneous rise on both monitors.
    block_sigs = 2'b11;
    pulses = 0;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clock);
      if (irq) pulses++;
      if (k == 16) begin
        check("both_vec", deadlock_vec, 2'b11);
        check("both_idx", deadlock_idx, 0);
      end
    end
    check("both_pulses", pulses, 1);
    release_latch();

    // Randomised traffic, mostly-high blocks so confirmations happen.
    repeat (400) begin
      enable = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NUM_MON; i++) block_sigs[i] = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 39) == 0);
      @(negedge clock);
    end

    // Timestamp saturation: bring to MON with zero counts, confirm.
    block_sigs = '0; enable = 1'b1; clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("sat_state", state, 1);
    block_sigs = 2'b11;
    repeat (16) @(negedge clock);
    check("sat_ts", deadlock_ts, 8'hFF);
    check("sat_vec", deadlock_vec, 2'b11);
    release_latch();

    // Asynchronous reset mid-count.
    block_sigs = 2'b01;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_deadlock", deadlock, 0);
    check("arst_irq", irq, 0);
    check("arst_ts", deadlock_ts, 0);
    check("arst_evt", event_count, 0);
    @(negedge clock);
    reset = 1'b1; block_sigs = '0;
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
